rv32_cpu_top: RTL and testbench

Single-cycle RV32I-subset processor core with on-chip instruction and data memories and a board debug view (LED and seven-segment value selection). It is the top of the processor hierarchy: board wrapper above, datapath/control and the register file below. Each instruction completes in one clock: fetch, decode, execute, memory access and register writeback.

---
 rtl/rv32_cpu_top_pkg.sv | 40 ++++
 rtl/rv32_cpu_top_register_file.sv | 24 ++
 rtl/rv32_cpu_top.sv | 167 ++++++++++++++++
 tb/tb_rv32_cpu_top.sv | 117 +++++++++++
 4 files changed

// File: rtl/rv32_cpu_top_pkg.sv
// rv32_cpu_top_pkg: shared opcode/funct constants, decode enums and the default boot program
package rv32_cpu_top_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  // Encoded as {funct7[5], funct3} so R-type decode is a direct cast
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_e;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int PROG_WORDS = 32;
  // Word 0 sits in the least significant 32 bits
  localparam logic [PROG_WORDS*32-1:0] DEFAULT_PROG = {
    {(PROG_WORDS-6){NOP_INSTR}},
    32'h0020F333, 32'h0020E2B3, 32'h40208233,
    32'h002081B3, 32'h00300113, 32'h00A00093
  };
endpackage

// File: rtl/rv32_cpu_top_register_file.sv
// rv32_cpu_top_register_file: 32x32 register file, x0 hardwired to zero
//   clk, rst (async, active-low) | ra1_i/ra2_i -> rd1_o/rd2_o combinational reads
//   we_i/wa_i/wd_i synchronous write port
module rv32_cpu_top_register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] regs [0:31];
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we_i && wa_i != 5'd0)
      regs[wa_i] <= wd_i;
  // regs[0] is cleared on reset and never written, so it always reads zero
  assign rd1_o = regs[ra1_i];
  assign rd2_o = regs[ra2_i];
endmodule

// File: rtl/rv32_cpu_top.sv
// rv32_cpu_top: single-cycle RV32I-subset core with instruction ROM, data RAM and debug view
//   clk, rst (async, active-low) | ledsel/ssdSel select the debug words on leds/ssd
//   ssdClk is a board-compatibility input | DEBUG_VIEW_EN builds the leds/ssd muxes, else both read 0
module rv32_cpu_top import rv32_cpu_top_pkg::*; #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64,
  parameter logic [PROG_WORDS*32-1:0] IMEM_INIT = DEFAULT_PROG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ledsel,
  input  logic [3:0]  ssdSel,
  input  logic        ssdClk,
  output logic [15:0] leds,
  output logic [12:0] ssd
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  logic [31:0] pc_q, pc_d, pc4, br_tgt, instr, imm, rs1_val, rs2_val;
  logic [31:0] alu_a, alu_b, alu_res, mem_rd, wb_val;
  logic [31:0] dmem_q [DMEM_WORDS];
  logic [IW-1:0] iidx;
  logic [DW-1:0] didx;
  logic [2:0] f3;
  logic reg_we, mem_we, b_imm, a_pc, branch, jal, jalr, cond, taken;
  imm_e imm_t;
  wb_e wb_sel;
  alu_op_e alu_op;
  logic unused_ok;
  // Words past the stored program read as NOP; the index wraps at the memory depth
  assign iidx = pc_q[IW+1:2];
  assign instr = 32'(iidx) < PROG_WORDS ? IMEM_INIT[32*iidx +: 32] : NOP_INSTR;
  assign f3 = instr[14:12];
  always_comb
    imm = imm_t == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
          imm_t == IMM_B ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
          imm_t == IMM_U ? {instr[31:12], 12'b0} :
          imm_t == IMM_J ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
          {{20{instr[31]}}, instr[31:20]};
  always_comb begin
    reg_we = 1'b0;
    mem_we = 1'b0;
    b_imm = 1'b0;
    a_pc = 1'b0;
    branch = 1'b0;
    jal = 1'b0;
    jalr = 1'b0;
    imm_t = IMM_I;
    wb_sel = WB_ALU;
    alu_op = ALU_ADD;
    case (instr[6:0])
      OPC_OP: begin
        reg_we = instr[31:25] == F7_ZERO || (instr[31:25] == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
        alu_op = alu_op_e'({instr[30], f3});
      end
      OPC_OP_IMM: begin
        reg_we = 1'b1;
        b_imm = 1'b1;
        // bit 30 selects srai only; for addi it is part of the immediate
        alu_op = alu_op_e'({f3 == F3_SR && instr[30], f3});
      end
      OPC_LOAD: begin
        reg_we = f3 == F3_W;
        b_imm = 1'b1;
        wb_sel = WB_MEM;
      end
      OPC_STORE: begin
        mem_we = f3 == F3_W;
        b_imm = 1'b1;
        imm_t = IMM_S;
      end
      OPC_BRANCH: begin
        branch = 1'b1;
        imm_t = IMM_B;
      end
      OPC_JAL: begin
        reg_we = 1'b1;
        jal = 1'b1;
        imm_t = IMM_J;
        wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        reg_we = f3 == F3_ADD;
        jalr = f3 == F3_ADD;
        b_imm = 1'b1;
        wb_sel = WB_PC4;
      end
      OPC_LUI: begin
        reg_we = 1'b1;
        imm_t = IMM_U;
        wb_sel = WB_IMM;
      end
      OPC_AUIPC: begin
        reg_we = 1'b1;
        imm_t = IMM_U;
        a_pc = 1'b1;
        b_imm = 1'b1;
      end
      default: ;
    endcase
  end
  rv32_cpu_top_register_file rf (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (instr[19:15]),
    .ra2_i (instr[24:20]),
    .we_i  (reg_we),
    .wa_i  (instr[11:7]),
    .wd_i  (wb_val),
    .rd1_o (rs1_val),
    .rd2_o (rs2_val)
  );
  assign alu_a = a_pc ? pc_q : rs1_val;
  assign alu_b = b_imm ? imm : rs2_val;
  always_comb
    case (alu_op)
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLL:  alu_res = alu_a << alu_b[4:0];
      ALU_SLT:  alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'b0, alu_a < alu_b};
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SRL:  alu_res = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_res = $signed(alu_a) >>> alu_b[4:0];
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
      default:  alu_res = alu_a + alu_b;
    endcase
  // funct3[2:1] picks eq/lt/ltu, funct3[0] inverts; 010/011 are not branches
  assign cond = f3[2] ? (f3[1] ? rs1_val < rs2_val : $signed(rs1_val) < $signed(rs2_val)) : rs1_val == rs2_val;
  assign taken = branch && f3[2:1] != 2'b01 && (cond ^ f3[0]);
  assign pc4 = pc_q + 32'd4;
  assign br_tgt = pc_q + imm;
  assign pc_d = jalr ? {alu_res[31:1], 1'b0} : (jal || taken) ? br_tgt : pc4;
  assign didx = alu_res[DW+1:2];
  assign mem_rd = dmem_q[didx];
  assign wb_val = wb_sel == WB_MEM ? mem_rd : wb_sel == WB_PC4 ? pc4 : wb_sel == WB_IMM ? imm : alu_res;
  always_ff @(posedge clk or negedge rst)
    if (!rst) pc_q <= '0;
    else pc_q <= pc_d;
  // No reset on the RAM contents; a store is dropped while reset is held
  always_ff @(posedge clk)
    if (rst && mem_we) dmem_q[didx] <= rs2_val;
`ifdef DEBUG_VIEW_EN
  logic [12:0] ctrl;
  assign ctrl = {reg_we, mem_we, b_imm, a_pc, branch, jal, jalr, wb_sel, alu_op};
  always_comb
    leds = ledsel == 2'd0 ? pc_q[15:0] : ledsel == 2'd1 ? instr[15:0] : ledsel == 2'd2 ? instr[31:16] : {3'b0, ctrl};
  always_comb
    case (ssdSel)
      4'd0:    ssd = pc_q[12:0];
      4'd1:    ssd = pc4[12:0];
      4'd2:    ssd = br_tgt[12:0];
      4'd3:    ssd = rs1_val[12:0];
      4'd4:    ssd = rs2_val[12:0];
      4'd5:    ssd = wb_val[12:0];
      4'd6:    ssd = imm[12:0];
      4'd7:    ssd = alu_res[12:0];
      4'd8:    ssd = mem_rd[12:0];
      default: ssd = '0;
    endcase
  assign unused_ok = ssdClk;
`else
  assign leds = '0;
  assign ssd = '0;
  assign unused_ok = ^{ssdClk, ledsel, ssdSel};
`endif
endmodule

// File: tb/tb_rv32_cpu_top.sv
// tb_rv32_cpu_top: directed checks of the default program, a feature program, debug view and async reset
module tb_rv32_cpu_top;
  import rv32_cpu_top_pkg::*;
`ifdef DEBUG_VIEW_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif
  // Feature program: x0 write, sw/lw, beq skip, jal, slt/sltu, lui+srai/sra, jalr, auipc
  localparam logic [31:0] TP [22] = '{
    32'h00D00193, 32'h00500013, 32'h00302423, 32'h00802383,
    32'h00A00093, 32'h00108463, 32'h06300693, 32'hFFF00493,
    32'h0080046F, 32'h04D00713, 32'h00100513, 32'h00A4A5B3,
    32'h00A4B633, 32'h800007B7, 32'h4047D813, 32'h00400893,
    32'h4117D933, 32'h05000A13, 32'h001A09E7, 32'h03700A93,
    32'h04200B13, 32'h00001B97
  };
  function automatic logic [PROG_WORDS*32-1:0] mk_prog();
    logic [PROG_WORDS*32-1:0] p;
    p = {PROG_WORDS{NOP_INSTR}};
    for (int i = 0; i < 22; i++) p[i*32 +: 32] = TP[i];
    return p;
  endfunction
  logic clk = 1'b0, rst, ssd_clk;
  logic [1:0] ledsel;
  logic [3:0] ssd_sel;
  logic [15:0] leds, leds_t;
  logic [12:0] ssd, ssd_t;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  rv32_cpu_top u_dut (
    .clk    (clk),
    .rst    (rst),
    .ledsel (ledsel),
    .ssdSel (ssd_sel),
    .ssdClk (ssd_clk),
    .leds   (leds),
    .ssd    (ssd)
  );
  rv32_cpu_top #(.IMEM_INIT(mk_prog())) u_tst (
    .clk    (clk),
    .rst    (rst),
    .ledsel (ledsel),
    .ssdSel (ssd_sel),
    .ssdClk (ssd_clk),
    .leds   (leds_t),
    .ssd    (ssd_t)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  initial begin
    logic [31:0] exp_def [32];
    rst = 1'b0;
    ledsel = 2'd0;
    ssd_sel = 4'd0;
    ssd_clk = 1'b0;
    #12;
    check("reset_pc", u_dut.pc_q, 32'h0);
    check("reset_x1", u_dut.rf.regs[1], 32'h0);
    check("reset_leds", {16'h0, leds}, 32'h0);
    @(negedge clk) rst = 1'b1;
    repeat (25) @(negedge clk);
    exp_def = '{default: 32'h0};
    exp_def[1] = 32'd10;
    exp_def[2] = 32'd3;
    exp_def[3] = 32'd13;
    exp_def[4] = 32'd7;
    exp_def[5] = 32'd11;
    exp_def[6] = 32'd2;
    for (int i = 0; i < 32; i++) check($sformatf("def_x%0d", i), u_dut.rf.regs[i], exp_def[i]);
    check("def_pc", u_dut.pc_q, 32'h64);
    check("x0_write", u_tst.rf.regs[0], 32'h0);
    check("sw_mem", u_tst.dmem_q[2], 32'd13);
    check("lw_x7", u_tst.rf.regs[7], 32'd13);
    check("beq_skip_x13", u_tst.rf.regs[13], 32'h0);
    check("jal_link_x8", u_tst.rf.regs[8], 32'h24);
    check("jal_skip_x14", u_tst.rf.regs[14], 32'h0);
    check("addi_neg_x9", u_tst.rf.regs[9], 32'hFFFFFFFF);
    check("slt_x11", u_tst.rf.regs[11], 32'd1);
    check("sltu_x12", u_tst.rf.regs[12], 32'd0);
    check("lui_x15", u_tst.rf.regs[15], 32'h80000000);
    check("srai_x16", u_tst.rf.regs[16], 32'hF8000000);
    check("sra_x18", u_tst.rf.regs[18], 32'hF8000000);
    check("jalr_link_x19", u_tst.rf.regs[19], 32'h4C);
    check("jalr_skip_x21", u_tst.rf.regs[21], 32'h0);
    check("jalr_tgt_x22", u_tst.rf.regs[22], 32'd66);
    check("auipc_x23", u_tst.rf.regs[23], 32'h1054);
    check("leds_pc", {16'h0, leds}, DBG ? 32'h64 : 32'h0);
    check("ssd_pc", {19'h0, ssd}, DBG ? 32'h64 : 32'h0);
    ledsel = 2'd1;
    ssd_sel = 4'd1;
    #1;
    check("leds_instr_lo", {16'h0, leds}, DBG ? 32'h0013 : 32'h0);
    check("ssd_pc4", {19'h0, ssd}, DBG ? 32'h68 : 32'h0);
    ledsel = 2'd0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_pc", u_dut.pc_q, 32'h0);
    check("midrst_x1", u_dut.rf.regs[1], 32'h0);
    check("midrst_tst_x8", u_tst.rf.regs[8], 32'h0);
    check("midrst_leds", {16'h0, leds}, 32'h0);
    check("midrst_dmem_kept", u_tst.dmem_q[2], 32'd13);
    repeat (2) @(negedge clk);
    check("rst_hold_pc", u_dut.pc_q, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("restart_pc", u_dut.pc_q, 32'hC);
    check("restart_x3", u_dut.rf.regs[3], 32'd13);
    check("restart_x4", u_dut.rf.regs[4], 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
